// File: rtl/fifo_push_arbiter.sv
// Round-robin arbiter that shares one fifo push port among N requesters, with registered outputs.
// Build macro FIFO_ARB_PRIO0_EN: requester 0 takes strict priority over the round-robin group.
module fifo_push_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       data,
  output logic [N-1:0]         ack,
  input  logic                 fifo_full,
  input  logic                 fifo_error,
  output logic                 push_back,
  output logic [W-1:0]         data_in,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 halted
);
  localparam int IDW = $clog2(N);

  typedef enum logic [1:0] {IDLE, PUSH, HALT} state_t;

  state_t         state;
  logic           vld_p1;
  logic [N-1:0]   ack_p1;
  logic [W-1:0]   data_p1;
  logic [IDW-1:0] gid_p1;
  logic           halt_p1;

  logic [N-1:0]   rr_mask_p0;
  logic [IDW-1:0] win_p0;
  logic [W-1:0]   data_sel_p0;

  // First asserted request at or after last+1, wrapping; returns last when none is set.
  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] last);
    logic [IDW-1:0] win;
    logic           found;
    int             idx;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && r[idx]) begin
        win   = IDW'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

`ifdef FIFO_ARB_PRIO0_EN
  assign rr_mask_p0 = {{(N-1){1'b1}}, 1'b0};
  assign win_p0     = req[0] ? '0 : rr_pick(req & rr_mask_p0, gid_p1);
`else
  assign rr_mask_p0 = '1;
  assign win_p0     = rr_pick(req & rr_mask_p0, gid_p1);
`endif

  assign data_sel_p0 = data[int'(win_p0)*W +: W];

  // ---- stage p0 -> p1: arbitration decision registered onto the fifo push port ----
  always_ff @(posedge CLK) begin
    if (rst) begin
      state   <= IDLE;
      vld_p1  <= 1'b0;
      ack_p1  <= '0;
      data_p1 <= '0;
      gid_p1  <= IDW'(N-1);
      halt_p1 <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      ack_p1 <= '0;
      case (state)
        IDLE: begin
          if (fifo_error) begin
            state   <= HALT;
            halt_p1 <= 1'b1;
          end else if ((|req) && !fifo_full) begin
            vld_p1  <= 1'b1;
            ack_p1  <= N'(1) << win_p0;
            data_p1 <= data_sel_p0;
            gid_p1  <= win_p0;
            state   <= PUSH;
          end
        end
        // Gap cycle: fifo_full and the acked requester's req both catch up here.
        PUSH: begin
          if (fifo_error) begin
            state   <= HALT;
            halt_p1 <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        HALT: halt_p1 <= 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  assign push_back = vld_p1;
  assign ack       = ack_p1;
  assign data_in   = data_p1;
  assign grant_id  = gid_p1;
  assign halted    = halt_p1;
endmodule
